// File: rtl/crypto_arbiter.sv
// crypto_arbiter: round-robin sharing of one encrypt/decrypt core between NUM_REQ requesters.
// Optional WAIT-state watchdog is built when the macro CRYPTO_WDT_EN is defined.
module crypto_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int OWNER_W     = 1,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_op,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] req_done,
    output logic [NUM_REQ-1:0] req_err,
    output logic               core_start_enc,
    output logic               core_start_dec,
    input  logic               core_enc_done,
    input  logic               core_dec_done,
    output logic               busy,
    output logic [OWNER_W-1:0] owner_id
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t               state_r;
    logic [OWNER_W-1:0]   rr_ptr_r;
    logic [OWNER_W-1:0]   owner_id_r;
    logic                 op_r;
    logic [NUM_REQ-1:0]   grant_r;
    logic [NUM_REQ-1:0]   req_done_r;
    logic                 start_enc_r;
    logic                 start_dec_r;
    logic                 busy_r;
    logic [OWNER_W-1:0]   pick_idx_s;
    logic                 pick_valid_s;
    logic                 done_match_s;
    logic [OWNER_W-1:0]   rr_next_s;

`ifdef CRYPTO_WDT_EN
    logic [CNT_W-1:0]     wdt_cnt_r;
    logic [NUM_REQ-1:0]   req_err_r;
`else
    logic [CNT_W-1:0]     unused_cfg_s;
`endif

    function automatic logic [NUM_REQ-1:0] one_hot(input logic [OWNER_W-1:0] idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Round-robin pick: first requesting index at or after rr_ptr, wrapping at NUM_REQ
    always_comb begin
        logic [OWNER_W-1:0] cand;
        pick_valid_s = 1'b0;
        pick_idx_s   = '0;
        cand         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand         = OWNER_W'((int'(rr_ptr_r) + k) % NUM_REQ);
            pick_idx_s   = (req[cand] && !pick_valid_s) ? cand : pick_idx_s;
            pick_valid_s = pick_valid_s | req[cand];
        end
    end

    assign done_match_s = op_r ? core_dec_done : core_enc_done;
    assign rr_next_s    = (owner_id_r == OWNER_W'(NUM_REQ - 1)) ? '0 : owner_id_r + OWNER_W'(1);

    // Main sequencer; every output comes straight from a register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= '0;
            owner_id_r  <= '0;
            op_r        <= 1'b0;
            grant_r     <= '0;
            req_done_r  <= '0;
            start_enc_r <= 1'b0;
            start_dec_r <= 1'b0;
            busy_r      <= 1'b0;
`ifdef CRYPTO_WDT_EN
            wdt_cnt_r   <= '0;
            req_err_r   <= '0;
`endif
        end else begin
            start_enc_r <= 1'b0;
            start_dec_r <= 1'b0;
            req_done_r  <= '0;
`ifdef CRYPTO_WDT_EN
            req_err_r   <= '0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        owner_id_r  <= pick_idx_s;
                        op_r        <= req_op[pick_idx_s];
                        grant_r     <= one_hot(pick_idx_s);
                        start_enc_r <= ~req_op[pick_idx_s];
                        start_dec_r <= req_op[pick_idx_s];
                        busy_r      <= 1'b1;
                        state_r     <= ST_ISSUE;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
`ifdef CRYPTO_WDT_EN
                    wdt_cnt_r <= '0;
`endif
                    state_r   <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A matching done takes priority over a simultaneous timeout
                    if (done_match_s) begin
                        req_done_r <= one_hot(owner_id_r);
                        grant_r    <= '0;
                        state_r    <= ST_RELEASE;
                    end
`ifdef CRYPTO_WDT_EN
                    else if (wdt_cnt_r == CNT_W'(TIMEOUT_CYC)) begin
                        req_err_r  <= one_hot(owner_id_r);
                        grant_r    <= '0;
                        state_r    <= ST_RELEASE;
                    end else begin
                        wdt_cnt_r  <= wdt_cnt_r + CNT_W'(1);
                    end
`else
                    else begin
                        state_r    <= ST_WAIT;
                    end
`endif
                end
                ST_RELEASE: begin
                    rr_ptr_r <= rr_next_s;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    grant_r <= '0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant          = grant_r;
    assign req_done       = req_done_r;
    assign core_start_enc = start_enc_r;
    assign core_start_dec = start_dec_r;
    assign busy           = busy_r;
    assign owner_id       = owner_id_r;

`ifdef CRYPTO_WDT_EN
    assign req_err = req_err_r;
`else
    assign req_err      = '0;
    assign unused_cfg_s = CNT_W'(TIMEOUT_CYC);
`endif

endmodule

// File: tb/tb_crypto_arbiter.sv
// Bench for crypto_arbiter: vector table, directed corner sequences, and random traffic
// compared against a timestamp-based transaction model.
module tb_crypto_arbiter;

    localparam int N  = 2;
    localparam int OW = 1;
    localparam int TO = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req, req_op, grant, req_done, req_err;
    logic          core_start_enc, core_start_dec, core_enc_done, core_dec_done, busy;
    logic [OW-1:0] owner_id;

    int n_checks = 0;
    int n_errors = 0;

    crypto_arbiter #(.NUM_REQ(N), .OWNER_W(OW), .TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_op(req_op), .grant(grant),
        .req_done(req_done), .req_err(req_err), .core_start_enc(core_start_enc),
        .core_start_dec(core_start_dec), .core_enc_done(core_enc_done),
        .core_dec_done(core_dec_done), .busy(busy), .owner_id(owner_id)
    );

    always #5 clk = ~clk;

    // {grant, req_done, req_err, start_enc, start_dec, busy, owner_id}
    function automatic logic [9:0] observed();
        return {grant, req_done, req_err, core_start_enc, core_start_dec, busy, owner_id};
    endfunction

    task automatic check(input string name, input logic [9:0] exp);
        logic [9:0] act;
        act = observed();
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got g/d/e/se/sd/b/o=%b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [1:0] rq;
        logic [1:0] op;
        logic       enc;
        logic       dec;
        logic [9:0] exp;
    } vec_t;

    function automatic vec_t v(input logic [1:0] rq, input logic [1:0] op, input logic e,
                               input logic d, input logic [1:0] g, input logic [1:0] dn,
                               input logic se, input logic sd, input logic b, input logic o);
        return {rq, op, e, d, g, dn, 2'b00, se, sd, b, o};
    endfunction

    vec_t vecs[24];

    // Transaction model: grant cycle m_g, completion-pulse cycle m_d (-1 while pending)
    bit m_act, m_err;
    int m_g, m_d, m_idle_from, m_owner, m_op, m_rr;

    initial begin
        rst = 1'b1; req = '0; req_op = '0; core_enc_done = 1'b0; core_dec_done = 1'b0;
        #2;
        check("reset_async", 10'b0);
        tick(); tick();
        check("reset_hold", 10'b0);
        rst = 1'b0;

        // req, op, enc_done, dec_done -> grant, done, start_enc, start_dec, busy, owner
        vecs[0]  = v(2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[1]  = v(2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[2]  = vecs[1];
        vecs[3]  = vecs[1];
        vecs[4]  = vecs[1];
        vecs[5]  = v(2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[6]  = v(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[7]  = v(2'b10, 2'b10, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
        vecs[8]  = v(2'b00, 2'b00, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[9]  = vecs[8];
        vecs[10] = v(2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[11] = v(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[12] = v(2'b11, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[13] = v(2'b11, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[14] = v(2'b11, 2'b00, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[15] = v(2'b11, 2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[16] = v(2'b11, 2'b11, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
        vecs[17] = v(2'b11, 2'b00, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[18] = v(2'b11, 2'b00, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[19] = v(2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[20] = v(2'b11, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[21] = v(2'b00, 2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[22] = v(2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[23] = vecs[6];

        for (int i = 0; i < 24; i++) begin
            req = vecs[i].rq; req_op = vecs[i].op;
            core_enc_done = vecs[i].enc; core_dec_done = vecs[i].dec;
            tick();
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Reset in WAIT (rr_ptr is 1 here, so requester 1 wins)
        req = 2'b10; req_op = 2'b00; core_enc_done = 1'b0; core_dec_done = 1'b0;
        tick();
        check("rst_seq_grant", {2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1});
        req = 2'b00;
        tick(); tick();
        #2 rst = 1'b1;
        #1 check("rst_mid_op", 10'b0);
        tick();
        rst = 1'b0;
        req = 2'b10;
        tick();
        check("rst_after_grant", {2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1});
        req = 2'b00;
        tick();
        core_enc_done = 1'b1;
        tick();
        check("rst_after_done", {2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1});
        core_enc_done = 1'b0;
        tick();

`ifdef CRYPTO_WDT_EN
        req = 2'b11; req_op = 2'b00;
        tick();
        check("wdt_grant0", {2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0});
        for (int k = 1; k <= TO + 1; k++) begin
            tick();
            check($sformatf("wdt_wait%0d", k), {2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0});
        end
        tick();
        check("wdt_err", {2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0});
        tick(); tick();
        check("wdt_next_grant", {2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1});
        for (int k = 1; k <= TO + 1; k++) tick();
        core_enc_done = 1'b1;
        tick();
        check("wdt_done_wins", {2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1});
        core_enc_done = 1'b0; req = 2'b00;
        tick(); tick();
`else
        req = 2'b01; req_op = 2'b00;
        tick();
        check("nowdt_grant", {2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0});
        req = 2'b00;
        for (int k = 1; k <= 40; k++) begin
            tick();
            check($sformatf("nowdt_hold%0d", k), {2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0});
        end
        core_enc_done = 1'b1;
        tick();
        check("nowdt_done", {2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0});
        core_enc_done = 1'b0;
        tick(); tick();
`endif

        // Random traffic against the transaction model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_act = 1'b0; m_err = 1'b0; m_g = 0; m_d = -1; m_idle_from = 0;
        m_owner = 0; m_op = 0; m_rr = 0;
        for (int c = 0; c < 3000; c++) begin
            int e;
            logic [1:0] eg, ed, ee;
            req           = 2'($urandom_range(3, 0));
            req_op        = 2'($urandom_range(3, 0));
            core_enc_done = ($urandom_range(3, 0) == 0);
            core_dec_done = ($urandom_range(3, 0) == 0);
            if (m_act && m_d >= 0 && c == m_d) begin
                m_act = 1'b0;
                m_idle_from = c + 1;
                m_rr = (m_owner + 1) % N;
            end else if (!m_act && c >= m_idle_from && req != 2'b00) begin
                for (int k = 0; k < N; k++) begin
                    if (!m_act && req[(m_rr + k) % N]) begin
                        m_owner = (m_rr + k) % N;
                        m_op = int'(req_op[m_owner]);
                        m_act = 1'b1;
                    end
                end
                m_g = c + 1; m_d = -1; m_err = 1'b0;
            end else if (m_act && m_d < 0 && c > m_g) begin
                if ((m_op == 0 && core_enc_done) || (m_op == 1 && core_dec_done)) begin
                    m_d = c + 1;
                end
`ifdef CRYPTO_WDT_EN
                else if (c == m_g + 1 + TO) begin
                    m_d = c + 1;
                    m_err = 1'b1;
                end
`endif
            end
            tick();
            e  = c + 1;
            eg = (m_act && (m_d < 0 || e < m_d)) ? 2'(1 << m_owner) : 2'b00;
            ed = (m_act && e == m_d && !m_err) ? 2'(1 << m_owner) : 2'b00;
            ee = (m_act && e == m_d && m_err) ? 2'(1 << m_owner) : 2'b00;
            check($sformatf("rand%0d", c),
                  {eg, ed, ee, (m_act && e == m_g && m_op == 0), (m_act && e == m_g && m_op == 1),
                   m_act, OW'(m_owner)});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
